// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a return-address stack.
// Ports: clk, rstn (sync low), stall, op_valid, op, target, resume ->
//   pc, pc_valid, halted, err, err_ovf, err_unf, stack_level.
module pc_sequencer #(
  parameter int ADDR_W      = 5,
  parameter int STACK_DEPTH = 4,
  parameter int LVL_W       = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              stall,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] target,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              halted,
  output logic              err,
  output logic              err_ovf,
  output logic              err_unf,
  output logic [LVL_W-1:0]  stack_level
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_HALT = 3'd4;

  typedef enum logic [1:0] {
    S_START,
    S_RUN,
    S_HALT,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              valid_q, halted_q;
  logic              push;
  logic              full, empty;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  assign pc_inc = pc_q + ADDR_W'(1);
  assign full   = (lvl_q >= LVL_W'(STACK_DEPTH));
  assign empty  = (lvl_q == '0);
  // Depth is a power of two, so the low level bits address the slot;
  // the top entry sits one below the write slot (wraps when full).
  assign wr_idx = lvl_q[IDX_W-1:0];
  assign rd_idx = wr_idx - IDX_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    lvl_d   = lvl_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    unique case (state_q)
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (!stall) begin
          pc_d = pc_inc;
          if (op_valid) begin
            unique case (op)
              OP_JMP: pc_d = target;
              OP_CALL: begin
                if (full) begin
                  pc_d    = pc_q;
                  ovf_d   = 1'b1;
                  state_d = S_ERROR;
                end else begin
                  push  = 1'b1;
                  pc_d  = target;
                  lvl_d = lvl_q + LVL_W'(1);
                end
              end
              OP_RET: begin
                if (empty) begin
                  pc_d    = pc_q;
                  unf_d   = 1'b1;
                  state_d = S_ERROR;
                end else begin
                  pc_d  = stack_mem[rd_idx];
                  lvl_d = lvl_q - LVL_W'(1);
                end
              end
              OP_HALT: begin
                pc_d    = pc_q;
                state_d = S_HALT;
              end
              default: ;
            endcase
          end
        end
      end
      S_HALT: begin
        if (resume) begin
          pc_d    = pc_inc;
          state_d = S_RUN;
        end
      end
      S_ERROR: ;
      default: state_d = S_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_START;
      pc_q     <= '0;
      lvl_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      lvl_q    <= lvl_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      valid_q  <= (state_d == S_RUN);
      halted_q <= (state_d == S_HALT);
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack_mem[wr_idx] <= pc_inc;
  end

  assign pc          = pc_q;
  assign pc_valid    = valid_q;
  assign halted      = halted_q;
  assign err_ovf     = ovf_q;
  assign err_unf     = unf_q;
  assign err         = ovf_q | unf_q;
  assign stack_level = lvl_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table for pc_sequencer.
// Drives on negedge, checks #1 after posedge.
module tb_pc_sequencer;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] JMP  = 3'd1;
  localparam logic [2:0] CALL = 3'd2;
  localparam logic [2:0] RET  = 3'd3;
  localparam logic [2:0] HALT = 3'd4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       stall;
  logic       op_valid;
  logic [2:0] op;
  logic [4:0] target;
  logic       resume;
  logic [4:0] pc;
  logic       pc_valid;
  logic       halted;
  logic       err;
  logic       err_ovf;
  logic       err_unf;
  logic [2:0] stack_level;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W(5),
    .STACK_DEPTH(4),
    .LVL_W(3)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .stall(stall),
    .op_valid(op_valid),
    .op(op),
    .target(target),
    .resume(resume),
    .pc(pc),
    .pc_valid(pc_valid),
    .halted(halted),
    .err(err),
    .err_ovf(err_ovf),
    .err_unf(err_unf),
    .stack_level(stack_level)
  );

  typedef struct {
    logic       r;
    logic       s;
    logic       v;
    logic [2:0] o;
    logic [4:0] t;
    logic       rs;
    logic [4:0] e_pc;
    logic       e_pv;
    logic       e_h;
    logic       e_ovf;
    logic       e_unf;
    logic [2:0] e_lvl;
  } vec_t;

  vec_t vq[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic add(input logic r, s, v, input logic [2:0] o,
                     input logic [4:0] t, input logic rs,
                     input logic [4:0] epc, input logic epv, eh,
                     input logic eo, eu, input logic [2:0] el);
    vec_t x;
    x.r = r; x.s = s; x.v = v; x.o = o; x.t = t; x.rs = rs;
    x.e_pc = epc; x.e_pv = epv; x.e_h = eh;
    x.e_ovf = eo; x.e_unf = eu; x.e_lvl = el;
    vq.push_back(x);
  endtask

  task automatic step(input vec_t x, input string name);
    @(negedge clk);
    rstn = x.r; stall = x.s; op_valid = x.v;
    op = x.o; target = x.t; resume = x.rs;
    @(posedge clk);
    #1;
    n_run++;
    if (pc !== x.e_pc || pc_valid !== x.e_pv || halted !== x.e_h ||
        err_ovf !== x.e_ovf || err_unf !== x.e_unf ||
        err !== (x.e_ovf | x.e_unf) || stack_level !== x.e_lvl) begin
      n_fail++;
      $display("FAIL %s: got pc=%0d pv=%0b h=%0b ovf=%0b unf=%0b err=%0b lvl=%0d want pc=%0d pv=%0b h=%0b ovf=%0b unf=%0b err=%0b lvl=%0d",
               name, pc, pc_valid, halted, err_ovf, err_unf, err, stack_level,
               x.e_pc, x.e_pv, x.e_h, x.e_ovf, x.e_unf,
               x.e_ovf | x.e_unf, x.e_lvl);
    end
  endtask

  task automatic run1(input logic r, s, v, input logic [2:0] o,
                      input logic [4:0] t, input logic rs,
                      input logic [4:0] epc, input logic epv, eh,
                      input logic eo, eu, input logic [2:0] el,
                      input string name);
    vec_t x;
    x.r = r; x.s = s; x.v = v; x.o = o; x.t = t; x.rs = rs;
    x.e_pc = epc; x.e_pv = epv; x.e_h = eh;
    x.e_ovf = eo; x.e_unf = eu; x.e_lvl = el;
    step(x, name);
  endtask

  initial begin
    rstn = 1'b0; stall = 1'b0; op_valid = 1'b0;
    op = NOP; target = '0; resume = 1'b0;

    //   r s v op    tgt rs  pc pv h  o  u  lvl
    add(0,0,0,NOP ,  0,0,   0,0,0, 0,0, 0);
    add(1,0,0,NOP ,  0,0,   0,1,0, 0,0, 0);
    add(1,0,0,NOP ,  0,0,   1,1,0, 0,0, 0);
    add(1,0,0,NOP ,  0,0,   2,1,0, 0,0, 0);
    add(1,0,0,NOP ,  0,0,   3,1,0, 0,0, 0);
    add(1,0,1,JMP , 20,0,  20,1,0, 0,0, 0);
    add(1,0,0,NOP ,  0,0,  21,1,0, 0,0, 0);
    add(1,0,1,JMP ,  5,0,   5,1,0, 0,0, 0);
    add(1,0,1,CALL, 12,0,  12,1,0, 0,0, 1);
    add(1,0,0,NOP ,  0,0,  13,1,0, 0,0, 1);
    add(1,0,1,RET ,  0,0,   6,1,0, 0,0, 0);
    add(1,0,0,NOP ,  0,0,   7,1,0, 0,0, 0);
    add(1,0,1,JMP , 31,0,  31,1,0, 0,0, 0);
    add(1,0,1,CALL,  2,0,   2,1,0, 0,0, 1);
    add(1,0,1,RET ,  0,0,   0,1,0, 0,0, 0);
    add(1,1,1,JMP , 25,0,   0,1,0, 0,0, 0);
    add(1,1,1,JMP , 25,0,   0,1,0, 0,0, 0);
    add(1,1,1,JMP , 25,0,   0,1,0, 0,0, 0);
    add(1,0,1,JMP , 25,0,  25,1,0, 0,0, 0);
    add(1,0,0,NOP ,  0,0,  26,1,0, 0,0, 0);
    add(1,0,1,3'd6,  3,0,  27,1,0, 0,0, 0);
    add(1,0,0,JMP ,  3,0,  28,1,0, 0,0, 0);
    add(1,0,1,JMP ,  9,0,   9,1,0, 0,0, 0);
    add(1,0,1,HALT,  0,0,   9,0,1, 0,0, 0);
    add(1,1,1,JMP ,  3,0,   9,0,1, 0,0, 0);
    add(1,0,1,CALL,  4,0,   9,0,1, 0,0, 0);
    add(1,0,1,RET ,  0,0,   9,0,1, 0,0, 0);
    add(1,1,1,JMP ,  1,0,   9,0,1, 0,0, 0);
    add(1,0,1,HALT,  0,0,   9,0,1, 0,0, 0);
    add(1,0,0,NOP ,  0,1,  10,1,0, 0,0, 0);
    add(1,0,0,NOP ,  0,0,  11,1,0, 0,0, 0);
    add(1,0,0,NOP ,  0,1,  12,1,0, 0,0, 0);
    add(1,0,1,CALL, 20,0,  20,1,0, 0,0, 1);
    add(1,0,1,CALL, 21,0,  21,1,0, 0,0, 2);
    add(0,0,1,CALL,  5,0,   0,0,0, 0,0, 0);
    add(1,0,0,NOP ,  0,0,   0,1,0, 0,0, 0);
    add(1,0,1,CALL, 10,0,  10,1,0, 0,0, 1);
    add(1,0,1,CALL, 20,0,  20,1,0, 0,0, 2);
    add(1,0,1,CALL, 30,0,  30,1,0, 0,0, 3);
    add(1,0,1,CALL,  4,0,   4,1,0, 0,0, 4);
    add(1,0,1,RET ,  0,0,  31,1,0, 0,0, 3);
    add(1,0,1,RET ,  0,0,  21,1,0, 0,0, 2);
    add(1,0,1,RET ,  0,0,  11,1,0, 0,0, 1);
    add(1,0,1,RET ,  0,0,   1,1,0, 0,0, 0);
    add(1,0,1,CALL,  8,0,   8,1,0, 0,0, 1);
    add(1,0,1,CALL,  8,0,   8,1,0, 0,0, 2);
    add(1,0,1,CALL,  8,0,   8,1,0, 0,0, 3);
    add(1,0,1,CALL, 16,0,  16,1,0, 0,0, 4);
    add(1,0,1,CALL,  3,0,  16,0,0, 1,0, 4);
    add(1,0,1,RET ,  0,0,  16,0,0, 1,0, 4);
    add(1,0,1,JMP ,  0,1,  16,0,0, 1,0, 4);
    add(1,1,0,NOP ,  0,1,  16,0,0, 1,0, 4);
    add(0,0,0,NOP ,  0,0,   0,0,0, 0,0, 0);
    add(1,0,0,NOP ,  0,0,   0,1,0, 0,0, 0);
    add(1,0,1,RET ,  0,0,   0,0,0, 0,1, 0);
    add(1,0,1,JMP ,  7,1,   0,0,0, 0,1, 0);
    add(0,0,0,NOP ,  0,0,   0,0,0, 0,0, 0);
    add(1,0,0,NOP ,  0,0,   0,1,0, 0,0, 0);

    for (int i = 0; i < vq.size(); i++)
      step(vq[i], $sformatf("vec%0d", i));

    for (int i = 1; i < 32; i++)
      run1(1,0,0,NOP,0,0, 5'(i),1,0, 0,0, 0, $sformatf("wrap%0d", i));
    run1(1,0,1,HALT,0,0, 31,0,1, 0,0, 0, "halt_at_31");
    run1(1,0,0,NOP ,0,0, 31,0,1, 0,0, 0, "halt_hold_31");
    run1(1,0,0,NOP ,0,1,  0,1,0, 0,0, 0, "resume_wrap");
    run1(1,0,0,NOP ,0,0,  1,1,0, 0,0, 0, "after_resume");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
